// File: rtl/chan_packet_snapphase_ctrl.sv
// Phase-snapshot capture sequencer: arm/trigger/abort control, qualified sample writes to the snapshot BRAM, status word.
// Optional build macro SNAPPHASE_TIMESTAMP_EN records the trigger-cycle timestamp at address 0.
module chan_packet_snapphase_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHAN_W = 8
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic              trig,
  input  logic              in_valid,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              done,
  output logic [31:0]       snap_status
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'({ADDR_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ctrl_q;
  logic              arm_edge, force_edge, abort_edge, trig_hit, qual;
  logic              all_chans_q, latch_sel;
  logic [CHAN_W-1:0] sel_chan_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              unused_ctrl;

  assign arm_edge    = ctrl[0] & ~ctrl_q[0];
  assign force_edge  = ctrl[1] & ~ctrl_q[1];
  assign abort_edge  = ctrl[2] & ~ctrl_q[2];
  assign trig_hit    = trig | force_edge;
  assign qual        = in_valid & (all_chans_q | (in_chan == sel_chan_q));
  assign unused_ctrl = ^{ctrl[31:CHAN_W+8], ctrl[7:4]};

`ifdef SNAPPHASE_TIMESTAMP_EN
  logic [31:0] ts_q;

  // Free-running timestamp, sampled on the trigger cycle
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) ts_q <= '0;
    else             ts_q <= ts_q + 32'd1;
  end
`endif

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Abort has priority over every other transition, including a simultaneous arm
  always_comb begin
    state_d = state_q;
    if (abort_edge) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm_edge) state_d = S_ARMED;
        S_ARMED:        if (trig_hit) state_d = S_CAPTURE;
        S_CAPTURE:      if (qual && (count_q == LAST_ADDR)) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the write port, word count and channel selection
  always_comb begin
    we_d      = 1'b0;
    addr_d    = bram_addr;
    data_d    = bram_data;
    count_d   = count_q;
    latch_sel = 1'b0;
    if (!abort_edge) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_edge) begin
            count_d   = '0;
            latch_sel = 1'b1;
          end
        end
        S_ARMED: begin
`ifdef SNAPPHASE_TIMESTAMP_EN
          if (trig_hit) begin
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = DATA_W'(ts_q);
            count_d = CNT_W'(1);
          end
`endif
        end
        S_CAPTURE: begin
          if (qual) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(count_q);
            data_d  = in_data;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q      <= '0;
      count_q     <= '0;
      sel_chan_q  <= '0;
      all_chans_q <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_data   <= '0;
      done        <= 1'b0;
      snap_status <= '0;
    end else begin
      ctrl_q      <= ctrl[2:0];
      count_q     <= count_d;
      bram_we     <= we_d;
      bram_addr   <= addr_d;
      bram_data   <= data_d;
      done        <= (state_d == S_DONE);
      // Status trails the state/count registers by one cycle
      snap_status <= {done,
                      (state_q == S_ARMED) || (state_q == S_CAPTURE),
                      (state_q == S_ARMED),
                      29'(count_q)};
      if (latch_sel) begin
        sel_chan_q  <= ctrl[CHAN_W+7:8];
        all_chans_q <= ctrl[3];
      end
    end
  end

endmodule
